// File: rtl/cpa_chunk_seq.sv
// Multi-cycle wide adder: one CHUNK-bit prefix adder slice reused over WIDTH/CHUNK cycles.
// Latency: out_valid rises NCHUNK clock edges after the accept edge; one transaction in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, clr aborts anywhere.
module cpa_chunk_seq #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LEVELS = (CHUNK > 1) ? $clog2(CHUNK) : 0;
  localparam logic [IDXW-1:0]  LAST = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject geometries where the slices would not tile the operand exactly.
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("cpa_chunk_seq: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_r, b_r, sum_q;
  logic              carry, cout_q;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  slice_s;
  logic              slice_co;
  logic [WIDTH-1:0]  sum_d;

  // Slice adder: Kogge-Stone prefix over the current operand slice, carry folded into bit 0.
  always_comb begin
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] sa, sb, p0, cv;
    logic [CHUNK-1:0] gl [LEVELS+1];
    logic [CHUNK-1:0] pl [LEVELS+1];
    int               sh;
    sh   = int'(idx) * CHUNK;
    a_sh = a_r >> sh;
    b_sh = b_r >> sh;
    sa   = a_sh[CHUNK-1:0];
    sb   = b_sh[CHUNK-1:0];
    p0   = sa ^ sb;
    for (int l = 0; l <= LEVELS; l++) begin
      gl[l] = '0;
      pl[l] = '0;
    end
    gl[0]    = sa & sb;
    gl[0][0] = gl[0][0] | (p0[0] & carry);
    pl[0]    = p0;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < CHUNK; i++) begin
        if (i >= (1 << l)) begin
          gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
          pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
        end else begin
          gl[l+1][i] = gl[l][i];
          pl[l+1][i] = pl[l][i];
        end
      end
    end
    // gl[LEVELS][i] is the carry out of bit i, including the slice carry-in.
    cv    = '0;
    cv[0] = carry;
    for (int i = 1; i < CHUNK; i++) begin
      cv[i] = gl[LEVELS][i-1];
    end
    slice_s  = p0 ^ cv;
    slice_co = gl[LEVELS][CHUNK-1];
    // Only the active slice of the result register changes; others keep their contents.
    sum_d = (sum_q & ~(SLICE_MASK << sh)) | (WIDTH'(slice_s) << sh);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; clr overrides every transition.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_valid)   state_d = S_RUN;
        S_RUN:   if (idx == LAST) state_d = S_DONE;
        S_DONE:  if (out_ready)  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand capture, slice sequencing and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (clr) begin
      idx <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        S_RUN: begin
          sum_q <= sum_d;
          carry <= slice_co;
          if (idx == LAST) begin
            cout_q <= slice_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cpa_chunk_seq.sv
// Bench for cpa_chunk_seq: three instances (CHUNK 6, 24, 1) over a 24-bit operand.
// Directed scenarios run on the CHUNK=6 instance; randomized traffic runs on all three.
// Expected results come from plain a+b+cin arithmetic and the NCHUNK edge latency rule.
module tb_cpa_chunk_seq;

  logic        clk;
  logic        rst_n;
  logic        clr_v       [3];
  logic        in_valid_v  [3];
  logic        in_ready_v  [3];
  logic        cin_v       [3];
  logic        out_valid_v [3];
  logic        out_ready_v [3];
  logic        cout_v      [3];
  logic        busy_v      [3];
  logic [23:0] a_v         [3];
  logic [23:0] b_v         [3];
  logic [23:0] sum_v       [3];

  int checks;
  int errors;

  cpa_chunk_seq #(.WIDTH(24), .CHUNK(6)) u_c6 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum_v[0]), .cout(cout_v[0]), .busy(busy_v[0])
  );

  cpa_chunk_seq #(.WIDTH(24), .CHUNK(24)) u_c24 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum_v[1]), .cout(cout_v[1]), .busy(busy_v[1])
  );

  cpa_chunk_seq #(.WIDTH(24), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum_v[2]), .cout(cout_v[2]), .busy(busy_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Reference: 25-bit result {cout,sum} of a+b+cin.
  function automatic logic [24:0] ref_add(input logic [23:0] x, input logic [23:0] y, input logic c);
    return 25'(x) + 25'(y) + 25'(c);
  endfunction

  // Drives one cycle of in_valid from a falling edge; returns on the falling edge after.
  task automatic present(input int k, input logic [23:0] av, input logic [23:0] bv, input logic cv);
    a_v[k] = av;
    b_v[k] = bv;
    cin_v[k] = cv;
    in_valid_v[k] = 1'b1;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clr_v[k] = 1'b0; in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy_v[k], out_valid_v[k], cout_v[k], sum_v[k]} !== 27'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got busy/ov/cout/sum %0h want 0", k,
                 {busy_v[k], out_valid_v[k], cout_v[k], sum_v[k]});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({in_ready_v[k], busy_v[k], out_valid_v[k]} !== 3'b100) begin
        errors++;
        $display("FAIL reset_release[%0d] got rdy/busy/ov %b want 100", k,
                 {in_ready_v[k], busy_v[k], out_valid_v[k]});
      end
    end
  endtask

  task automatic test_carry_ripple;
    present(0, 24'hFFFFFF, 24'h000001, 1'b0);
    checks++;
    if ({busy_v[0], in_ready_v[0], out_valid_v[0]} !== 3'b100) begin
      errors++;
      $display("FAIL ripple_run_flags got busy/rdy/ov %b want 100", {busy_v[0], in_ready_v[0], out_valid_v[0]});
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (out_valid_v[0] !== 1'(j == 4)) begin
        errors++;
        $display("FAIL ripple_latency edge %0d got out_valid %b want %b", j, out_valid_v[0], j == 4);
      end
    end
    checks++;
    if ({cout_v[0], sum_v[0]} !== 25'h1_000000) begin
      errors++;
      $display("FAIL ripple_result got %h want 1000000", {cout_v[0], sum_v[0]});
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    checks++;
    if ({in_ready_v[0], out_valid_v[0], busy_v[0]} !== 3'b100) begin
      errors++;
      $display("FAIL ripple_return got rdy/ov/busy %b want 100", {in_ready_v[0], out_valid_v[0], busy_v[0]});
    end
  endtask

  task automatic test_operand_hold;
    present(0, 24'h123456, 24'h654321, 1'b1);
    a_v[0] = 24'($urandom);
    b_v[0] = 24'($urandom);
    cin_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    repeat (4) @(negedge clk);
    in_valid_v[0] = 1'b0;
    checks++;
    if ({out_valid_v[0], cout_v[0], sum_v[0]} !== {1'b1, 25'h0_777778}) begin
      errors++;
      $display("FAIL hold_result got ov/cout/sum %h want 1 0 777778", {out_valid_v[0], cout_v[0], sum_v[0]});
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [23:0] ra, rb;
    logic        rc;
    logic [24:0] exp;
    ra = 24'($urandom);
    rb = 24'($urandom);
    rc = 1'($urandom_range(0, 1));
    exp = ref_add(ra, rb, rc);
    present(0, ra, rb, rc);
    repeat (4) @(negedge clk);
    in_valid_v[0] = 1'b1;
    for (int h = 0; h < 10; h++) begin
      checks++;
      if ({out_valid_v[0], in_ready_v[0], cout_v[0], sum_v[0]} !== {2'b10, exp}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got ov/rdy/cout/sum %h want %h", h,
                 {out_valid_v[0], in_ready_v[0], cout_v[0], sum_v[0]}, {2'b10, exp});
      end
      a_v[0] = 24'($urandom);
      @(negedge clk);
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    in_valid_v[0] = 1'b0;
    checks++;
    if ({in_ready_v[0], busy_v[0], out_valid_v[0]} !== 3'b100) begin
      errors++;
      $display("FAIL stall_release got rdy/busy/ov %b want 100", {in_ready_v[0], busy_v[0], out_valid_v[0]});
    end
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_accept got busy %b want 0", busy_v[0]);
    end
  endtask

  task automatic test_clr;
    present(0, 24'($urandom), 24'($urandom), 1'b0);
    repeat (2) @(negedge clk);
    clr_v[0] = 1'b1;
    in_valid_v[0] = 1'b1;
    a_v[0] = 24'($urandom);
    @(negedge clk);
    clr_v[0] = 1'b0;
    in_valid_v[0] = 1'b0;
    checks++;
    if ({in_ready_v[0], busy_v[0], out_valid_v[0]} !== 3'b100) begin
      errors++;
      $display("FAIL clr_abort got rdy/busy/ov %b want 100", {in_ready_v[0], busy_v[0], out_valid_v[0]});
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if ({out_valid_v[0], busy_v[0]} !== 2'b00) begin
        errors++;
        $display("FAIL clr_quiet cycle %0d got ov/busy %b want 00", j, {out_valid_v[0], busy_v[0]});
      end
    end
    present(0, 24'h800000, 24'h800000, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({out_valid_v[0], cout_v[0], sum_v[0]} !== {1'b1, 25'h1_000001}) begin
      errors++;
      $display("FAIL clr_next_txn got ov/cout/sum %h want 1 1 000001", {out_valid_v[0], cout_v[0], sum_v[0]});
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_async_reset;
    present(0, 24'hABCDEF, 24'h123456, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_v[0], out_valid_v[0], cout_v[0], sum_v[0]} !== 27'h0) begin
      errors++;
      $display("FAIL async_reset got busy/ov/cout/sum %h want 0", {busy_v[0], out_valid_v[0], cout_v[0], sum_v[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_release got in_ready %b want 1", in_ready_v[0]);
    end
    present(0, 24'h000FFF, 24'h000001, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if ({out_valid_v[0], cout_v[0], sum_v[0]} !== {1'b1, 25'h0_001000}) begin
      errors++;
      $display("FAIL async_next_txn got ov/cout/sum %h want 1 0 001000", {out_valid_v[0], cout_v[0], sum_v[0]});
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_random(input int k, input int ntx, input int nch);
    logic [23:0] ra, rb;
    logic        rc, seen;
    logic [24:0] exp;
    int          j, gap, hold;
    for (int t = 0; t < ntx; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        a_v[k] = 24'($urandom);
        out_ready_v[k] = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      ra = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 24'h000001 : 24'($urandom);
      rc = 1'($urandom_range(0, 1));
      exp = ref_add(ra, rb, rc);
      checks++;
      if (in_ready_v[k] !== 1'b1) begin
        errors++;
        $display("FAIL rand[%0d] txn %0d in_ready got %b want 1", k, t, in_ready_v[k]);
      end
      present(k, ra, rb, rc);
      j = 0;
      seen = 1'b0;
      while (!seen && j <= nch + 1) begin
        if (out_valid_v[k] === 1'b1) begin
          seen = 1'b1;
        end else begin
          checks++;
          if (in_ready_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL rand[%0d] txn %0d run in_ready got %b want 0", k, t, in_ready_v[k]);
          end
          in_valid_v[k] = 1'($urandom_range(0, 1));
          a_v[k] = 24'($urandom);
          b_v[k] = 24'($urandom);
          cin_v[k] = 1'($urandom_range(0, 1));
          out_ready_v[k] = 1'($urandom_range(0, 1));
          @(negedge clk);
          j++;
        end
      end
      checks++;
      if (!seen || j != nch) begin
        errors++;
        $display("FAIL rand[%0d] txn %0d latency got %0d edges (seen %b) want %0d", k, t, j, seen, nch);
      end
      if (seen) begin
        hold = $urandom_range(0, 3);
        for (int h = 0; h <= hold; h++) begin
          checks++;
          if ({out_valid_v[k], in_ready_v[k], cout_v[k], sum_v[k]} !== {2'b10, exp}) begin
            errors++;
            $display("FAIL rand[%0d] txn %0d result a=%h b=%h cin=%b got ov/rdy/cout/sum %h want %h",
                     k, t, ra, rb, rc, {out_valid_v[k], in_ready_v[k], cout_v[k], sum_v[k]}, {2'b10, exp});
          end
          in_valid_v[k] = 1'($urandom_range(0, 1));
          out_ready_v[k] = 1'(h == hold);
          @(negedge clk);
        end
        out_ready_v[k] = 1'b0;
        in_valid_v[k] = 1'b0;
        checks++;
        if ({in_ready_v[k], busy_v[k], out_valid_v[k]} !== 3'b100) begin
          errors++;
          $display("FAIL rand[%0d] txn %0d release got rdy/busy/ov %b want 100", k, t,
                   {in_ready_v[k], busy_v[k], out_valid_v[k]});
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_carry_ripple();
    test_operand_hold();
    test_backpressure();
    test_clr();
    test_async_reset();
    fork
      test_random(0, 3000, 4);
      test_random(1, 4000, 1);
      test_random(2, 800, 24);
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
